// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Read-side drain stage for the single-port-RAM FIFO. It issues read strobes,
//   absorbs the FIFO's fixed read latency and presents the words on a
//   valid/ready stream. A small skid buffer is filled under a credit rule, so
//   back-pressure never loses or duplicates a word.
//
// Ports
//   t_clk       rising-edge clock (FIFO read-port clock)
//   rst         synchronous reset, active-high
//   enable      run request; 0 stops new reads, in-flight words still delivered
//   fifo_empty  FIFO empty flag
//   fifo_r_en   FIFO read strobe, one word per high cycle
//   fifo_rdata  FIFO read data, valid RD_LATENCY cycles after fifo_r_en
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream word
//   busy        FSM not idle or buffer non-empty
//   words_out   accepted stream beats, wraps modulo 2^CNT_WIDTH
//
// state | meaning
// IDLE  | no reads issued, waiting for enable
// RUN   | reads issued while FIFO non-empty and credit available
// STOP  | enable dropped, waiting for in-flight reads to land
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  t_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("fifo_stream_drain: RD_LATENCY must be in 1..4");
    end
    if (BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
        $error("fifo_stream_drain: BUF_DEPTH must be >= RD_LATENCY+2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [CNT_WIDTH-1:0]    words_q, words_d;
    logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];

    logic [INF_W-1:0]        inflight;
    logic                    credit_ok;
    logic                    capture;
    logic                    accept;

    // Pointers wrap by compare-and-clear so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe_q[i]);
        end
    end

    // Credit counts words already buffered plus reads still in the latency
    // pipe; a pop in the same cycle is deliberately not credited so the
    // read strobe never depends on m_ready.
    assign credit_ok = (int'(occ_q) + int'(inflight)) < BUF_DEPTH;
    assign fifo_r_en = (state_q == RUN) && !fifo_empty && credit_ok;

    assign capture   = pipe_q[RD_LATENCY-1];
    assign m_valid   = (occ_q != '0);
    assign m_data    = buf_q[rd_ptr_q];
    assign accept    = m_valid && m_ready;
    assign busy      = (state_q != IDLE) || m_valid;
    assign words_out = words_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN:  if (!enable) state_d = STOP;
            STOP: begin
                if (enable) begin
                    state_d = RUN;
                end else if (inflight == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Shift in the new strobe; the cast drops the oldest stage.
        pipe_d   = RD_LATENCY'({pipe_q, fifo_r_en});
        wr_ptr_d = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = accept  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        words_d  = accept  ? words_q + CNT_WIDTH'(1) : words_q;
        occ_d    = occ_q;
        case ({capture, accept})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            words_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            words_q  <= words_d;
            if (capture) begin
                buf_q[wr_ptr_q] <= fifo_rdata;
            end
        end
    end

    // The credit rule makes this unreachable; firing means the credit
    // accounting is broken.
    a_no_overflow: assert property (@(posedge t_clk) disable iff (rst)
        !(capture && (occ_q == OCC_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: instance A uses default parameters
// (RD_LATENCY=1, BUF_DEPTH=4), instance B uses RD_LATENCY=3, BUF_DEPTH=5,
// CNT_WIDTH=4. Each instance has a FIFO model, a scoreboard queue filled when
// words are loaded, and a monitor that pops and compares on every accepted beat.
module tb_fifo_stream_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A ----------------
    logic        rst_a, en_a, empty_a, ren_a, mv_a, mr_a, busy_a;
    logic [31:0] rdata_a, md_a, wo_a;
    logic [31:0] fmem_a [0:511];
    int          wr_a = 0;
    int          rd_a = 0;
    int          acc_a = 0;
    logic [31:0] exp_a[$];
    logic        stall_a = 1'b0;
    logic [31:0] last_a = '0;
    logic [31:0] w_a;

    fifo_stream_drain u_dut_a (
        .t_clk(clk), .rst(rst_a), .enable(en_a), .fifo_empty(empty_a),
        .fifo_r_en(ren_a), .fifo_rdata(rdata_a), .m_valid(mv_a),
        .m_ready(mr_a), .m_data(md_a), .busy(busy_a), .words_out(wo_a)
    );

    assign empty_a = (rd_a == wr_a);
    always @(posedge clk) begin
        if (ren_a) begin
            rdata_a <= fmem_a[rd_a];
            rd_a    <= rd_a + 1;
        end
    end

    // ---------------- instance B ----------------
    logic        rst_b, en_b, empty_b, ren_b, mv_b, mr_b, busy_b;
    logic [31:0] rdata_b, md_b;
    logic [3:0]  wo_b;
    logic [31:0] fmem_b [0:511];
    logic [31:0] dl_b [0:2];
    int          wr_b = 0;
    int          rd_b = 0;
    logic [31:0] exp_b[$];
    logic        stall_b = 1'b0;
    logic [31:0] last_b = '0;
    logic [31:0] w_b;

    fifo_stream_drain #(
        .DATA_WIDTH(32), .RD_LATENCY(3), .BUF_DEPTH(5), .CNT_WIDTH(4)
    ) u_dut_b (
        .t_clk(clk), .rst(rst_b), .enable(en_b), .fifo_empty(empty_b),
        .fifo_r_en(ren_b), .fifo_rdata(rdata_b), .m_valid(mv_b),
        .m_ready(mr_b), .m_data(md_b), .busy(busy_b), .words_out(wo_b)
    );

    assign empty_b = (rd_b == wr_b);
    assign rdata_b = dl_b[2];
    always @(posedge clk) begin
        dl_b[0] <= ren_b ? fmem_b[rd_b] : 32'hDEAD_BEEF;
        dl_b[1] <= dl_b[0];
        dl_b[2] <= dl_b[1];
        if (ren_b) rd_b <= rd_b + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] w);
        fmem_a[wr_a] = w;
        exp_a.push_back(w);
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [31:0] w);
        fmem_b[wr_b] = w;
        exp_b.push_back(w);
        wr_b = wr_b + 1;
    endtask

    task automatic drain_a(input int max, input string name);
        int k = 0;
        while ((exp_a.size() != 0 || mv_a) && k < max) begin
            tick();
            k++;
        end
        chk(name, (k >= max) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic idle_a(input int max, input string name);
        int k = 0;
        while (busy_a && k < max) begin
            tick();
            k++;
        end
        chk(name, {31'd0, busy_a}, 32'd0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_a) begin
            stall_a = 1'b0;
        end else begin
            if (ren_a) chk("a_ren_while_empty", {31'd0, empty_a}, 32'd0);
            if (stall_a) begin
                chk("a_hold_valid", {31'd0, mv_a}, 32'd1);
                chk("a_hold_data", md_a, last_a);
            end
            if (mv_a && mr_a) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_beat", md_a, 32'hFFFF_FFFF);
                end else begin
                    w_a = exp_a.pop_front();
                    chk("a_beat", md_a, w_a);
                end
                acc_a++;
            end
            stall_a = mv_a && !mr_a;
            last_a  = md_a;
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            stall_b = 1'b0;
        end else begin
            if (ren_b) chk("b_ren_while_empty", {31'd0, empty_b}, 32'd0);
            if (stall_b) begin
                chk("b_hold_valid", {31'd0, mv_b}, 32'd1);
                chk("b_hold_data", md_b, last_b);
            end
            if (mv_b && mr_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_beat", md_b, 32'hFFFF_FFFF);
                end else begin
                    w_b = exp_b.pop_front();
                    chk("b_beat", md_b, w_b);
                end
            end
            stall_b = mv_b && !mr_b;
            last_b  = md_b;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int k;
        rst_a = 1'b1; rst_b = 1'b1;
        en_a  = 1'b0; en_b  = 1'b0;
        mr_a  = 1'b0; mr_b  = 1'b0;
        tick(); tick(); tick();

        chk("rst_ren", {31'd0, ren_a}, 32'd0);
        chk("rst_valid", {31'd0, mv_a}, 32'd0);
        chk("rst_data", md_a, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_words", wo_a, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Reset then stream 0x00..0x07
        for (int i = 0; i < 8; i++) push_a(32'(i));
        mr_a = 1'b1;
        en_a = 1'b1;
        chk("s1_no_ren_at_enable", {31'd0, ren_a}, 32'd0);
        tick();
        chk("s1_first_ren", {31'd0, ren_a}, 32'd1);
        chk("s1_valid_e1", {31'd0, mv_a}, 32'd0);
        tick();
        chk("s1_valid_e2", {31'd0, mv_a}, 32'd0);
        tick();
        chk("s1_first_data", md_a, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("s1_stream_valid", {31'd0, mv_a}, 32'd1);
            tick();
        end
        chk("s1_valid_end", {31'd0, mv_a}, 32'd0);
        chk("s1_words", wo_a, 32'd8);
        chk("s1_ren_empty", {31'd0, ren_a}, 32'd0);
        chk("s1_busy_run", {31'd0, busy_a}, 32'd1);
        en_a = 1'b0;
        idle_a(10, "s1_idle_timeout");

        // Back-pressure: 20 words, m_ready low for cycles 5..14
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) push_a(32'h100 + 32'(i));
        en_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mr_a = !(c >= 5 && c <= 14);
            if (c == 14) begin
                chk("bp_credit_full", 32'(rd_a - acc_a), 32'd4);
                chk("bp_ren_stopped", {31'd0, ren_a}, 32'd0);
                chk("bp_valid_held", {31'd0, mv_a}, 32'd1);
            end
            tick();
        end
        drain_a(100, "bp_drain_timeout");
        chk("bp_words", wo_a, 32'd20);
        en_a = 1'b0;
        idle_a(10, "bp_idle_timeout");

        // Stop mid-stream with 2 buffered, 1 in flight
        for (int i = 0; i < 6; i++) push_a(32'h200 + 32'(i));
        mr_a = 1'b0;
        base = rd_a;
        en_a = 1'b1;
        tick(); tick(); tick();
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stop_reads", 32'(rd_a - base), 32'd3);
        chk("stop_busy", {31'd0, busy_a}, 32'd1);
        chk("stop_valid", {31'd0, mv_a}, 32'd1);
        mr_a = 1'b1;
        k = 0;
        while (exp_a.size() > 3 && k < 50) begin
            tick();
            k++;
        end
        chk("stop_beats_timeout", (k >= 50) ? 32'd1 : 32'd0, 32'd0);
        tick(); tick();
        chk("stop_busy_low", {31'd0, busy_a}, 32'd0);
        chk("stop_words", wo_a, 32'd23);
        chk("stop_no_more_reads", 32'(rd_a - base), 32'd3);
        en_a = 1'b1;
        drain_a(50, "resume_drain_timeout");
        chk("resume_words", wo_a, 32'd26);
        en_a = 1'b0;
        idle_a(10, "resume_idle_timeout");

        // Mid-operation reset with occ=3
        for (int i = 0; i < 6; i++) push_a(32'h300 + 32'(i));
        mr_a = 1'b0;
        base = rd_a;
        en_a = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_reads", 32'(rd_a - base), 32'd4);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("mrst_valid", {31'd0, mv_a}, 32'd0);
        chk("mrst_words", wo_a, 32'd0);
        chk("mrst_busy", {31'd0, busy_a}, 32'd0);
        chk("mrst_ren", {31'd0, ren_a}, 32'd0);
        // Words read before the reset are gone; the scoreboard drops them.
        k = rd_a - acc_a;
        for (int i = 0; i < k; i++) void'(exp_a.pop_front());
        acc_a = rd_a;
        mr_a = 1'b1;
        tick();
        drain_a(50, "mrst_drain_timeout");
        chk("mrst_words_after", wo_a, 32'd2);
        en_a = 1'b0;
        idle_a(10, "mrst_idle_timeout");

        // Instance B: counter wrap, then random ready with deep latency
        for (int i = 0; i < 18; i++) push_b(32'h400 + 32'(i));
        mr_b = 1'b1;
        en_b = 1'b1;
        k = 0;
        while ((exp_b.size() != 0 || mv_b) && k < 200) begin
            tick();
            k++;
        end
        chk("wrap_timeout", (k >= 200) ? 32'd1 : 32'd0, 32'd0);
        chk("wrap_words", {28'd0, wo_b}, 32'd2);

        for (int i = 0; i < 200; i++) push_b(32'h1000 + 32'(i));
        k = 0;
        while ((exp_b.size() != 0 || mv_b) && k < 5000) begin
            mr_b = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        mr_b = 1'b1;
        chk("rand_timeout", (k >= 5000) ? 32'd1 : 32'd0, 32'd0);
        chk("rand_words", {28'd0, wo_b}, 32'd10);
        en_b = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rand_busy_low", {31'd0, busy_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
